// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter: instruction fetch vs load/store, one transaction at a time over an 8-bit port.
// Tie policy: round-robin by default; `define ARB_LS_PRIORITY_EN makes load/store always win a tie.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [2:0]  ls_size,
   input  logic [31:0] ls_wdata,
   output logic        ls_accept,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]  state;
   logic [31:0] base;
   logic [31:0] wdata;
   logic [2:0]  n;
   logic [2:0]  cnt;
   logic [31:0] rbuf;
   logic [31:0] rbuf_nxt;
   logic [1:0]  bidx;
   logic [2:0]  ls_n;
   logic        owner_ls;
   logic        last_ls;
   logic        grant_ls;
   logic        wr_q;

   assign mem_wr = wr_q & rdy;

   always_comb begin
      case (ls_size)
         3'd1:    ls_n = 3'd1;
         3'd2:    ls_n = 3'd2;
         default: ls_n = 3'd4;
      endcase
   end

   always_comb begin
`ifdef ARB_LS_PRIORITY_EN
      grant_ls = ls_req;
`else
      grant_ls = ls_req && (!if_req || !last_ls);
`endif
   end

   // Edge index cnt samples the byte addressed two edges earlier.
   assign bidx = cnt[1:0] - 2'd2;

   always_comb begin
      rbuf_nxt = rbuf;
      if (cnt >= 3'd2) rbuf_nxt[{bidx, 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         base      <= 32'd0;
         wdata     <= 32'd0;
         n         <= 3'd0;
         cnt       <= 3'd0;
         rbuf      <= 32'd0;
         owner_ls  <= 1'b0;
         last_ls   <= 1'b0;
         wr_q      <= 1'b0;
         mem_a     <= 32'd0;
         mem_dout  <= 8'd0;
         if_done   <= 1'b0;
         ls_done   <= 1'b0;
         ls_accept <= 1'b0;
         if_data   <= 32'd0;
         ls_rdata  <= 32'd0;
      end else if (rdy) begin
         ls_accept <= 1'b0;
         case (state)
            S_IDLE: begin
               if (if_req || ls_req) begin
                  owner_ls  <= grant_ls;
                  last_ls   <= grant_ls;
                  ls_accept <= grant_ls;
                  cnt       <= 3'd1;
                  rbuf      <= 32'd0;
                  if (grant_ls) begin
                     base  <= ls_addr;
                     mem_a <= ls_addr;
                     n     <= ls_n;
                     wdata <= ls_wdata;
                     if (ls_we) begin
                        mem_dout <= ls_wdata[7:0];
                        wr_q     <= 1'b1;
                        state    <= S_WRITE;
                     end else begin
                        state <= S_READ;
                     end
                  end else begin
                     base  <= if_addr;
                     mem_a <= if_addr;
                     n     <= 3'd4;
                     state <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (cnt < n) mem_a <= base + {29'd0, cnt};
               rbuf <= rbuf_nxt;
               cnt  <= cnt + 3'd1;
               if (cnt == n + 3'd1) begin
                  state <= S_DONE;
                  if (owner_ls) begin
                     ls_done  <= 1'b1;
                     ls_rdata <= rbuf_nxt;
                  end else begin
                     if_done <= 1'b1;
                     if_data <= rbuf_nxt;
                  end
               end
            end
            S_WRITE: begin
               cnt <= cnt + 3'd1;
               if (cnt < n) begin
                  mem_a    <= base + {29'd0, cnt};
                  mem_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
               end else begin
                  wr_q    <= 1'b0;
                  ls_done <= 1'b1;
                  state   <= S_DONE;
               end
            end
            default: begin
               // Requests are deliberately ignored on this edge.
               if_done <= 1'b0;
               ls_done <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset: rst, synchronous, active-high; clock clk.
REQ-003 rdy  in  1  global enable; 0 freezes all internal state.
REQ-004 if_req  in  1  instruction-fetch request, level, held until if_done.
REQ-005 if_addr  in  32  fetch byte address; fetch size is always 4 bytes.
REQ-006 if_done  out  1  one-cycle pulse: if_data valid.
REQ-007 if_data  out  32  fetched word, byte at if_addr+k in bits [8k+7:8k].
REQ-008 ls_req  in  1  load/store request, level, held until ls_done.
REQ-009 ls_we  in  1  1 = store, 0 = load.
REQ-010 ls_addr  in  32  load/store byte address.
REQ-011 ls_size  in  3  byte count; 1, 2 or 4; any other value is treated as 4.
REQ-012 ls_wdata  in  32  store data, byte k taken from bits [8k+7:8k].
REQ-013 ls_accept  out  1  one-cycle pulse: ls request latched by the arbiter.
REQ-014 ls_done  out  1  one-cycle pulse: load data valid or store fully written.
REQ-015 ls_rdata  out  32  load data, byte k = mem[ls_addr+k]; unread upper bytes 0.
REQ-016 mem_a  out  32  RAM byte address, registered.
REQ-017 mem_wr  out  1  RAM write strobe, registered, gated by rdy.
REQ-018 mem_dout  out  8  RAM write byte, registered.
REQ-019 mem_din  in  8  RAM read byte; valid the cycle after the address is presented.

Function
REQ-020 The FSM SHALL have four states: IDLE, READ, WRITE, DONE.
REQ-021 Requests SHALL be sampled only in IDLE; the grant edge E0 latches address, size, data and owner, and moves to READ (IF or load) or WRITE (store).
REQ-022 An LS grant SHALL pulse ls_accept for the cycle after E0; IF grants produce no accept.
REQ-023 Read of N bytes: mem_a = base+k registered at edge Ek (k=0..N-1); mem_din sampled as byte k at E(k+2); done and data registered at E(N+1), state -> DONE.
REQ-024 Write of N bytes: mem_a = base+k, mem_dout = byte k, mem_wr = 1 registered at Ek (k=0..N-1); mem_wr = 0 and done registered at EN, state -> DONE.
REQ-025 DONE SHALL last exactly one cycle (done pulse high), then IDLE; requests are not sampled on the DONE->IDLE edge.
REQ-026 Latency grant edge -> done high: read N+1 cycles (IF: 5), write N cycles.
REQ-027 Address increments SHALL wrap modulo 2^32.
REQ-028 if_data/ls_rdata SHALL hold their last value between dones; only the owner's outputs update.
REQ-029 Tie rule (both requests in IDLE) SHALL follow REQ-036.
REQ-030 With rdy = 0, no register changes and mem_wr reads 0; operation resumes unchanged when rdy returns to 1.

Reset
REQ-031 At an rst edge: state IDLE; mem_wr, if_done, ls_done, ls_accept = 0; mem_a, mem_dout, if_data, ls_rdata = 0; last-served = IF.
REQ-032 rst mid-transaction SHALL abandon it with no done pulse; partial writes already made remain in RAM.
REQ-033 rst SHALL take priority over rdy = 0.

Configuration
REQ-034 Macro ARB_LS_PRIORITY_EN selects the tie policy.
REQ-035 Defined: on a tie, LS always wins.
REQ-036 Undefined: round-robin; on a tie, grant the requester not served last; last-served updates at every grant and resets to IF, so the first tie goes to LS.

Verification
REQ-037 IF only, if_addr=0x1000, RAM bytes 0x13,0x05,0x00,0x00 -> mem_a 0x1000..0x1003 on E0..E3; if_done high after E5; if_data = 0x00000513.
REQ-038 Store ls_we=1, size 2, addr 0x20, wdata 0xAABBCCDD -> mem_wr at 0x20 = 0xDD, 0x21 = 0xCC; ls_done after E2; ls_accept after E0.
REQ-039 Load size 1 at 0xFFFFFFFF, then size 2 at 0xFFFFFFFF -> first ls_rdata = mem[0xFFFFFFFF] zero-extended; second reads 0xFFFFFFFF then 0x00000000 (wrap).
REQ-040 if_req and ls_req both raised from reset, held -> LS served first, then IF; with ARB_LS_PRIORITY_EN and LS re-requesting, LS is served again before IF.
REQ-041 rst asserted at E2 of a 4-byte store -> no ls_done, mem_wr = 0 next cycle, state IDLE; a new if_req then completes normally.
REQ-042 rdy = 0 for 3 cycles during a 4-byte IF read -> if_data correct; if_done delayed by exactly 3 cycles.
